// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage: DEPTH-entry FIFO, valid/ready on both sides, 1-cycle latency.
// Ports: clk, rst (async high), flush_i, in_valid/data/ready, out_valid/data/ready, count_o, flush_cnt_o.
module pipe_elastic_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [15:0]                flush_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [15:0]      flush_cnt_q;
  logic             push;
  logic             pop;
  logic [16:0]      flush_sum;

  assign in_ready_o  = (count_q < CW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign count_o     = count_q;
  assign flush_cnt_o = flush_cnt_q;

  // Empty stage keeps presenting the last popped payload.
  assign out_data_o = out_valid_o ? mem_q[rd_ptr_q] : last_q;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  assign flush_sum = {1'b0, flush_cnt_q} + 17'(count_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else if (pop) begin
      last_q <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case (1'b1)
        push && !pop: count_q <= count_q + CW'(1);
        pop && !push: count_q <= count_q - CW'(1);
        default:      count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_q <= '0;
    end else if (flush_i) begin
      flush_cnt_q <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end

endmodule
